// File: rtl/onchip_stream_pkg.sv
// Shared constants and FSM state type for the on-chip wide stream reader.
package onchip_stream_pkg;

  localparam int unsigned MEM_DW    = 1024;
  localparam int unsigned OUT_DW    = 32;
  localparam int unsigned LANES     = MEM_DW / OUT_DW;
  localparam int unsigned LANE_W    = $clog2(LANES);
  localparam int unsigned ADDR_W    = 9;
  localparam int unsigned MEM_DEPTH = 313;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    CAPTURE,
    STREAM
  } state_e;

endpackage

// File: rtl/wide_word_serializer.sv
// Shift buffer plus one-word prefetch register, emitting a wide word as
// OUT_DW-bit ready/valid beats, lane 0 (least significant) first.
module wide_word_serializer
  import onchip_stream_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [MEM_DW-1:0] load_data,
  input  logic              load_first,
  input  logic              load_last,
  output logic              pf_valid,
  output logic [OUT_DW-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop
);

  logic [MEM_DW-1:0] sh_buf;
  logic [MEM_DW-1:0] pf_buf;
  logic              sh_last;
  logic              pf_first;
  logic              pf_last;
  logic [LANE_W-1:0] lane;
  logic              xfer;
  logic              word_end;

  assign xfer     = out_valid & out_ready;
  assign word_end = xfer && (lane == LANE_W'(LANES - 1));
  assign out_data = sh_buf[OUT_DW-1:0];

  // Shift buffer refills from prefetch (or straight from memory) on the
  // same edge the last lane is accepted, so words stream without a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_buf    <= '0;
      pf_buf    <= '0;
      sh_last   <= 1'b0;
      pf_first  <= 1'b0;
      pf_last   <= 1'b0;
      pf_valid  <= 1'b0;
      lane      <= '0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
    end else if (!out_valid || word_end) begin
      lane <= '0;
      if (pf_valid) begin
        sh_buf    <= pf_buf;
        sh_last   <= pf_last;
        out_valid <= 1'b1;
        out_sop   <= pf_first;
        out_eop   <= pf_last && (LANES == 1);
        pf_valid  <= 1'b0;
      end else if (load) begin
        sh_buf    <= load_data;
        sh_last   <= load_last;
        out_valid <= 1'b1;
        out_sop   <= load_first;
        out_eop   <= load_last && (LANES == 1);
      end else begin
        out_valid <= 1'b0;
        out_sop   <= 1'b0;
        out_eop   <= 1'b0;
      end
      if (pf_valid && load) begin
        pf_buf   <= load_data;
        pf_first <= load_first;
        pf_last  <= load_last;
        pf_valid <= 1'b1;
      end
    end else begin
      if (xfer) begin
        sh_buf  <= sh_buf >> OUT_DW;
        lane    <= lane + LANE_W'(1);
        out_sop <= 1'b0;
        out_eop <= sh_last && (lane == LANE_W'(LANES - 2));
      end
      if (load) begin
        pf_buf   <= load_data;
        pf_first <= load_first;
        pf_last  <= load_last;
        pf_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/onchip_wide_stream_reader.sv
// Reads a contiguous run of wide memory words on command and streams them
// out as OUT_DW-bit beats with a single outstanding read and one-word prefetch.
module onchip_wide_stream_reader
  import onchip_stream_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic              mem_clken,
  input  logic [MEM_DW-1:0] mem_readdata,
  output logic [OUT_DW-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned SUM_W = ADDR_W + 2;

  state_e            state, state_d;
  logic [ADDR_W-1:0] rd_addr, rd_addr_d;
  logic [CNT_W-1:0]  remaining, remaining_d;
  logic [ADDR_W-1:0] addr_d;
  logic              cs_d;
  logic              rd_first, rd_first_d;
  logic              rd_last, rd_last_d;
  logic              busy_d, done_d, error_d;
  logic              cap_pending;
  logic              pf_valid;
  logic              cmd_ok;
  logic              eop_xfer;

  assign mem_write = 1'b0;
  assign mem_clken = 1'b1;

  assign cmd_ok   = (word_count != '0) &&
                    (SUM_W'(base_addr) + SUM_W'(word_count) <= SUM_W'(MEM_DEPTH));
  assign eop_xfer = out_valid & out_ready & out_eop;

  // Next state and next values of the registered outputs.
  always_comb begin
    state_d     = state;
    cs_d        = 1'b0;
    addr_d      = mem_address;
    rd_addr_d   = rd_addr;
    remaining_d = remaining;
    rd_first_d  = rd_first;
    rd_last_d   = rd_last;
    busy_d      = busy;
    done_d      = 1'b0;
    error_d     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (cmd_ok) begin
            state_d     = FETCH;
            cs_d        = 1'b1;
            addr_d      = base_addr;
            rd_addr_d   = base_addr + ADDR_W'(1);
            remaining_d = word_count - CNT_W'(1);
            rd_first_d  = 1'b1;
            rd_last_d   = (word_count == CNT_W'(1));
            busy_d      = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      FETCH:   state_d = CAPTURE;
      CAPTURE: state_d = STREAM;
      STREAM: begin
        // Prefetch the next word only when nothing is in flight or parked.
        if (remaining != '0 && !mem_chipselect && !cap_pending && !pf_valid) begin
          cs_d        = 1'b1;
          addr_d      = rd_addr;
          rd_addr_d   = rd_addr + ADDR_W'(1);
          remaining_d = remaining - CNT_W'(1);
          rd_first_d  = 1'b0;
          rd_last_d   = (remaining == CNT_W'(1));
        end
        if (eop_xfer) begin
          state_d = IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      mem_chipselect <= 1'b0;
      mem_address    <= '0;
      rd_addr        <= '0;
      remaining      <= '0;
      rd_first       <= 1'b0;
      rd_last        <= 1'b0;
      cap_pending    <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      state          <= state_d;
      mem_chipselect <= cs_d;
      mem_address    <= addr_d;
      rd_addr        <= rd_addr_d;
      remaining      <= remaining_d;
      rd_first       <= rd_first_d;
      rd_last        <= rd_last_d;
      cap_pending    <= mem_chipselect;
      busy           <= busy_d;
      done           <= done_d;
      error          <= error_d;
    end
  end

  // Read data is valid the cycle after chipselect; capture it then.
  wide_word_serializer u_serializer (
    .clk        (clk),
    .reset      (reset),
    .load       (cap_pending),
    .load_data  (mem_readdata),
    .load_first (rd_first),
    .load_last  (rd_last),
    .pf_valid   (pf_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sop    (out_sop),
    .out_eop    (out_eop)
  );

endmodule

// File: tb/tb_onchip_wide_stream_reader.sv
// Directed and randomized checks of the wide stream reader against a
// beat-level reference model built from memory contents.
module tb_onchip_wide_stream_reader;
  import onchip_stream_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   word_count;
  logic              busy, done, error;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect, mem_write, mem_clken;
  logic [MEM_DW-1:0] mem_readdata;
  logic [OUT_DW-1:0] out_data;
  logic              out_valid, out_ready, out_sop, out_eop;

  logic [MEM_DW-1:0] mem [MEM_DEPTH];
  logic [MEM_DW-1:0] rd_q;

  int vectors = 0;
  int miscompares = 0;

  logic [OUT_DW+1:0] beat_q[$];
  int                addr_q[$];
  logic              cs_prev, eop_prev, prev_valid, prev_ready, prev_sop, prev_eop;
  logic [OUT_DW-1:0] prev_data;
  int                beats;

  onchip_wide_stream_reader dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .word_count     (word_count),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_sop        (out_sop),
    .out_eop        (out_eop)
  );

  always #5 clk = ~clk;

  // Memory with one-cycle read latency.
  always @(posedge clk)
    if (mem_chipselect && 32'(mem_address) < MEM_DEPTH) rd_q <= mem[mem_address];
  assign mem_readdata = rd_q;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check the current cycle's outputs against the model, then advance one clock.
  task automatic clk_cycle();
    logic [OUT_DW+1:0] e;
    if (!reset) begin
      if (mem_chipselect) begin
        chk("read_outstanding", 64'(cs_prev), 64'(0));
        if (addr_q.size() == 0) chk("unexpected_read", 64'(mem_chipselect), 64'(0));
        else chk("read_addr", 64'(mem_address), 64'(addr_q.pop_front()));
      end
      chk("done_pulse", 64'(done), 64'(eop_prev));
      if (eop_prev) chk("busy_after_eop", 64'(busy), 64'(0));
      if (prev_valid && !prev_ready)
        chk("stall_hold", 64'({out_valid, out_sop, out_eop, out_data}),
            64'({1'b1, prev_sop, prev_eop, prev_data}));
      if (out_valid && out_ready) begin
        if (beat_q.size() == 0) chk("extra_beat", 64'(out_valid), 64'(0));
        else begin
          e = beat_q.pop_front();
          chk("beat", 64'({out_eop, out_sop, out_data}), 64'(e));
        end
        beats++;
      end
    end
    cs_prev    = mem_chipselect & ~reset;
    eop_prev   = out_valid & out_ready & out_eop & ~reset;
    prev_valid = out_valid & ~reset;
    prev_ready = out_ready;
    prev_sop   = out_sop;
    prev_eop   = out_eop;
    prev_data  = out_data;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_error"}, 64'(error), 64'(0));
    chk({tag, "_cs"}, 64'(mem_chipselect), 64'(0));
    chk({tag, "_addr"}, 64'(mem_address), 64'(0));
    chk({tag, "_stream"}, 64'({out_valid, out_sop, out_eop, out_data}), 64'(0));
  endtask

  task automatic push_cmd(input int b, input int n);
    for (int w = 0; w < n; w++) begin
      addr_q.push_back(b + w);
      for (int l = 0; l < int'(LANES); l++)
        beat_q.push_back({(w == n - 1) && (l == int'(LANES) - 1), (w == 0) && (l == 0),
                          mem[b + w][l*OUT_DW +: OUT_DW]});
    end
  endtask

  task automatic run_cmd(input int b, input int n, input int pct, input int poke_at,
                         input int abort_at);
    int cyc;
    logic got_done;
    push_cmd(b, n);
    beats      = 0;
    base_addr  = ADDR_W'(b);
    word_count = (ADDR_W+1)'(n);
    start      = 1'b1;
    out_ready  = int'($urandom_range(99)) < pct;
    clk_cycle();
    start = 1'b0;
    chk("busy_on_start", 64'(busy), 64'(1));
    chk("cs_on_start", 64'(mem_chipselect), 64'(1));
    cyc = 0;
    got_done = 1'b0;
    while (!got_done && cyc < 200 + n * int'(LANES) * 20) begin
      out_ready = int'($urandom_range(99)) < pct;
      if (cyc == poke_at) begin
        start      = 1'b1;
        base_addr  = ADDR_W'(200);
        word_count = (ADDR_W+1)'(2);
      end
      if (abort_at > 0 && beats == abort_at) begin
        reset      = 1'b1;
        start      = 1'b1;
        base_addr  = ADDR_W'(0);
        word_count = (ADDR_W+1)'(1);
        clk_cycle();
        reset = 1'b0;
        start = 1'b0;
        beat_q.delete();
        addr_q.delete();
        check_reset_vals("abort");
        clk_cycle();
        chk("start_in_reset_ignored", 64'({busy, mem_chipselect}), 64'(0));
        return;
      end
      clk_cycle();
      start = 1'b0;
      cyc++;
      chk("no_error", 64'(error), 64'(0));
      got_done = done;
    end
    chk("done_seen", 64'(got_done), 64'(1));
    if (pct >= 100) chk("cmd_cycles", 64'(cyc), 64'(2 + int'(LANES) * n));
    clk_cycle();
    chk("busy_idle", 64'(busy), 64'(0));
    chk("beats_left", 64'(beat_q.size()), 64'(0));
    chk("reads_left", 64'(addr_q.size()), 64'(0));
  endtask

  task automatic bad_cmd(input int b, input int n);
    base_addr  = ADDR_W'(b);
    word_count = (ADDR_W+1)'(n);
    start      = 1'b1;
    clk_cycle();
    start = 1'b0;
    chk("reject_error", 64'(error), 64'(1));
    chk("reject_idle", 64'({busy, mem_chipselect}), 64'(0));
    clk_cycle();
    chk("reject_pulse_end", 64'({error, busy, mem_chipselect}), 64'(0));
  endtask

  initial begin
    int cnt;
    reset      = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    out_ready  = 1'b0;
    cs_prev    = 1'b0;
    eop_prev   = 1'b0;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    prev_sop   = 1'b0;
    prev_eop   = 1'b0;
    prev_data  = '0;
    beats      = 0;
    for (int w = 0; w < int'(MEM_DEPTH); w++)
      for (int l = 0; l < int'(LANES); l++)
        mem[w][l*OUT_DW +: OUT_DW] = (w == 5) ? 32'hA000_0000 + 32'(l) : $urandom;

    repeat (2) clk_cycle();
    start      = 1'b1;
    word_count = (ADDR_W+1)'(1);
    clk_cycle();
    reset = 1'b0;
    start = 1'b0;
    check_reset_vals("reset");
    chk("mem_write_tie", 64'(mem_write), 64'(0));
    chk("mem_clken_tie", 64'(mem_clken), 64'(1));
    clk_cycle();
    chk("start_in_reset_ignored", 64'({busy, mem_chipselect}), 64'(0));

    run_cmd(5, 1, 100, -1, 0);
    run_cmd(10, 3, 100, -1, 0);
    run_cmd(0, 4, 30, -1, 0);
    bad_cmd(300, 14);
    run_cmd(312, 1, 100, -1, 0);
    run_cmd(300, 13, 70, -1, 0);
    bad_cmd(7, 0);
    run_cmd(50, 3, 100, -1, 40);
    run_cmd(0, 1, 100, -1, 0);
    run_cmd(20, 2, 100, 10, 0);
    for (int k = 0; k < 4; k++) begin
      cnt = int'($urandom_range(1, 3));
      run_cmd(int'($urandom_range(0, MEM_DEPTH - cnt)), cnt, int'($urandom_range(40, 100)), -1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
